// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: round-robin sharing of one line-fill memory port between I-cache and D-cache refills
//   clk, reset_n                 clock and asynchronous active-low reset
//   ic_req_i/ic_addr_i/ic_comp_o I-cache request, line address, completion pulse
//   dc_req_i/dc_addr_i/dc_comp_o D-cache request, line address, completion pulse
//   rd_data_o/err_o              returned line and timeout flag, valid with a completion pulse
//   mem_req_o/mem_addr_o         memory request and latched line address
//   mem_comp_i/mem_data_i        memory completion strobe and line data
//   grant_o/busy_o               {dc,ic} one-hot owner and not-idle indication
module mem_refill_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int LINE_W  = 128,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ic_req_i,
   input  logic [ADDR_W-1:0] ic_addr_i,
   output logic              ic_comp_o,
   input  logic              dc_req_i,
   input  logic [ADDR_W-1:0] dc_addr_i,
   output logic              dc_comp_o,
   output logic [LINE_W-1:0] rd_data_o,
   output logic              err_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_comp_i,
   input  logic [LINE_W-1:0] mem_data_i,
   output logic [1:0]        grant_o,
   output logic              busy_o
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   state_t            state_q;
   logic              ptr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              pick_dc;
   // ptr_q=1 favours the D-cache when both request
   assign pick_dc = dc_req_i & (~ic_req_i | ptr_q);
   assign busy_o  = state_q != IDLE;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         ptr_q      <= 1'b0;
         cnt_q      <= '0;
         ic_comp_o  <= 1'b0;
         dc_comp_o  <= 1'b0;
         rd_data_o  <= '0;
         err_o      <= 1'b0;
         mem_req_o  <= 1'b0;
         mem_addr_o <= '0;
         grant_o    <= 2'b00;
      end else begin
         case (state_q)
            IDLE: if (ic_req_i | dc_req_i) begin
               state_q    <= REQ;
               mem_req_o  <= 1'b1;
               grant_o    <= pick_dc ? 2'b10 : 2'b01;
               mem_addr_o <= pick_dc ? dc_addr_i : ic_addr_i;
               cnt_q      <= '0;
            end
            REQ: begin
               // saturating count; the timeout exit normally fires long before
               cnt_q <= cnt_q + CNT_W'(cnt_q != '1);
               if (mem_comp_i || cnt_q == LAST) begin
                  state_q   <= RESP;
                  mem_req_o <= 1'b0;
                  rd_data_o <= mem_comp_i ? mem_data_i : '0;
                  err_o     <= ~mem_comp_i;
                  ic_comp_o <= grant_o[0];
                  dc_comp_o <= grant_o[1];
               end
            end
            RESP: begin
               state_q   <= IDLE;
               ic_comp_o <= 1'b0;
               dc_comp_o <= 1'b0;
               err_o     <= 1'b0;
               grant_o   <= 2'b00;
               ptr_q     <= grant_o[0];
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
